// File: rtl/multiplicador_param.sv
// -----------------------------------------------------------------------------
// multiplicador_param
// Parametrised sequential shift-add multiplier with signed/unsigned mode and a
// level handshake (Idle/Done). The MIPS control FSM raises St for MULT/MULTU,
// stalls until Done, then drops St to return the block to IDLE.
//
// Parameters
//   WIDTH  operand width (>= 4); Produto is 2*WIDTH bits
//   CNT_W  step counter width, derived from WIDTH (not meant to be overridden)
//
// Ports
//   Clk            system clock, rising edge
//   reset          asynchronous, active-low reset
//   St             start request, level-sensitive
//   Sgn            1 = two's-complement operands, 0 = unsigned (sampled with St)
//   Multiplicando  multiplicand (sampled with St)
//   Multiplicador  multiplier (sampled with St)
//   Idle           high in IDLE
//   Done           high in DONE
//   Produto        result register, holds until the next completion or reset
//
// Optional feature: define MULT_EARLY_TERM_EN to finish as soon as the
// remaining multiplier bits are all zero (one barrel shift applies the rest).
// -----------------------------------------------------------------------------
module multiplicador_param #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               Clk,
    input  logic               reset,
    input  logic               St,
    input  logic               Sgn,
    input  logic [WIDTH-1:0]   Multiplicando,
    input  logic [WIDTH-1:0]   Multiplicador,
    output logic               Idle,
    output logic               Done,
    output logic [2*WIDTH-1:0] Produto
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   acc_q,   acc_d;
    logic [WIDTH-1:0]   mplr_q,  mplr_d;
    logic               neg_q,   neg_d;
    logic               first_q, first_d;
    logic [2*WIDTH-1:0] prod_q,  prod_d;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH:0]   step_vec;
    logic [2*WIDTH-1:0] shifted;
    logic [2*WIDTH-1:0] result;
    logic               last_step;

    // Magnitudes: negating the most-negative value gives 2^(WIDTH-1), which is
    // exact in the WIDTH-bit unsigned datapath.
    assign a_mag = (Sgn && Multiplicando[WIDTH-1]) ? -Multiplicando : Multiplicando;
    assign b_mag = (Sgn && Multiplicador[WIDTH-1]) ? -Multiplicador : Multiplicador;

    // One shift-add step: WIDTH+1-bit add keeps the carry, which becomes the
    // new accumulator MSB after the right shift.
    assign sum      = {1'b0, acc_q} + {1'b0, mcand_q & {WIDTH{mplr_q[0]}}};
    assign step_vec = {sum, mplr_q};

`ifdef MULT_EARLY_TERM_EN
    // If nothing above the current LSB is set, every remaining step is a pure
    // shift, so apply all cnt_q shifts at once and finish on this edge.
    assign last_step = (cnt_q == CNT_ONE) || (mplr_q[WIDTH-1:1] == '0);
    assign shifted   = (2*WIDTH)'(step_vec >> (last_step ? cnt_q : CNT_ONE));
`else
    assign last_step = (cnt_q == CNT_ONE);
    assign shifted   = step_vec[2*WIDTH:1];
`endif

    // Negating zero yields zero, so no -0 artefact is possible.
    assign result = neg_q ? -shifted : shifted;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        mplr_d  = mplr_q;
        neg_d   = neg_q;
        first_d = first_q;
        prod_d  = prod_q;
        case (state_q)
            S_IDLE: begin
                if (St) begin
                    mcand_d = a_mag;
                    mplr_d  = b_mag;
                    neg_d   = Sgn & (Multiplicando[WIDTH-1] ^ Multiplicador[WIDTH-1]);
                    acc_d   = '0;
                    cnt_d   = CNT_INIT;
                    first_d = 1'b1;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (first_q) begin
                    // Settle cycle: places Done WIDTH+1 edges after the start
                    // sample, matching the controller's stall count.
                    first_d = 1'b0;
                end else if (last_step) begin
                    prod_d  = result;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    acc_d = shifted[2*WIDTH-1:WIDTH];
                    mplr_d = shifted[WIDTH-1:0];
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_DONE: begin
                // No restart while St stays high.
                if (!St) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            mplr_q  <= '0;
            neg_q   <= 1'b0;
            first_q <= 1'b0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            mplr_q  <= mplr_d;
            neg_q   <= neg_d;
            first_q <= first_d;
            prod_q  <= prod_d;
        end
    end

    assign Idle    = (state_q == S_IDLE);
    assign Done    = (state_q == S_DONE);
    assign Produto = prod_q;

endmodule
